alu_exec_sequencer: RTL and testbench

- Execute-stage controller that sits between the decode/issue stage and the combinational ALU.
- Accepts one operation at a time over a valid/ready handshake and registers the operands.
- Holds the ALU inputs stable for the op's latency: 1 cycle for simple ops, MUL_CYCLES for MUL, DIV_CYCLES for DIV.
- Captures result, flag and branch, presents them to the MEM/WB stage over a second valid/ready handshake, and keeps the architectural flag register used by BRFL.

---
 rtl/alu_exec_sequencer_pkg.sv | 35 +++
 rtl/alu_exec_sequencer_counter.sv | 30 +++
 rtl/alu_exec_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_sequencer_pkg.sv
// Shared opcode, function and flag encodings plus the sequencer state type
// for the execute-stage controller.
package alu_exec_pkg;

    localparam logic [2:0] OP_ADDI    = 3'b000;
    localparam logic [2:0] OP_SUBI    = 3'b001;
    localparam logic [2:0] OP_TYPE_R  = 3'b010;
    localparam logic [2:0] OP_ANDI    = 3'b011;
    localparam logic [2:0] OP_ORI     = 3'b100;
    localparam logic [2:0] OP_BRFL    = 3'b101;
    localparam logic [2:0] OP_CMP     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    localparam logic [5:0] FUNC_DIV = 6'b000001;
    localparam logic [5:0] FUNC_MUL = 6'b000010;

    localparam logic [2:0] FLAG_NOT_ACTIVED = 3'b000;
    localparam logic [2:0] FLAG_EQUAL       = 3'b001;
    localparam logic [2:0] FLAG_EXCEPTION   = 3'b010;
    localparam logic [2:0] FLAG_OVERFLOW    = 3'b011;
    localparam logic [2:0] FLAG_UNDERFLOW   = 3'b100;
    localparam logic [2:0] FLAG_ABOVE       = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic isRtype(input logic [2:0] ctrl, input logic [5:0] func,
                                     input logic [5:0] want);
        return (ctrl == OP_TYPE_R) && (func == want);
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_counter.sv
// Loadable down-counter that measures how long the ALU inputs are held.
module alu_latency_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] loadVal_i,
    input  logic             dec_i,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;

    // Load has priority; the count parks at zero instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - ONE;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer: holds ALU operands for the op's latency, captures
// the ALU outputs for MEM/WB and maintains the architectural flag register.
module alu_exec_sequencer
    import alu_exec_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [2:0]  issue_alu_control,
    input  logic [5:0]  issue_func,
    input  logic [31:0] issue_data_a,
    input  logic [31:0] issue_data_b,
    output logic [2:0]  alu_control,
    output logic [5:0]  alu_func,
    output logic [31:0] alu_data_a,
    output logic [31:0] alu_data_b,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flag,
    input  logic        alu_branch,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_result,
    output logic [2:0]  wb_flag,
    output logic        wb_branch,
    output logic        wb_illegal,
    output logic [2:0]  flag_reg,
    output logic        busy,
    output logic        stall
);

    state_e      state_q;
    logic [2:0]  aluCtrl_q;
    logic [5:0]  aluFunc_q;
    logic [31:0] aluA_q;
    logic [31:0] aluB_q;
    logic        wbValid_q;
    logic [31:0] wbResult_q;
    logic [2:0]  wbFlag_q;
    logic        wbBranch_q;
    logic        wbIllegal_q;
    logic [2:0]  flagReg_q;

    logic             issueReady;
    logic             accept;
    logic             cntZero;
    logic             divByZero;
    logic             capture;
    logic             isBrfl;
    logic             isIllegal;
    logic [CNT_W-1:0] latency_d;

    assign issueReady = (state_q == ST_IDLE) || ((state_q == ST_DONE) && wb_ready);
    assign accept     = issue_valid && issueReady;

    // The counter is loaded with latency-1 so a zero count means "capture now".
    always_comb begin
        latency_d = '0;
        if (isRtype(issue_alu_control, issue_func, FUNC_MUL)) begin
            latency_d = CNT_W'(MUL_CYCLES - 1);
        end else if (isRtype(issue_alu_control, issue_func, FUNC_DIV)) begin
            latency_d = CNT_W'(DIV_CYCLES - 1);
        end
    end

    alu_latency_counter #(.CNT_W(CNT_W)) u_counter (
        .clock    (clock),
        .reset    (reset),
        .load_i   (accept),
        .loadVal_i(latency_d),
        .dec_i    (state_q == ST_EXEC),
        .zero_o   (cntZero)
    );

    assign divByZero = isRtype(aluCtrl_q, aluFunc_q, FUNC_DIV) && (aluB_q == '0);
    assign capture   = (state_q == ST_EXEC) && (cntZero || divByZero);
    assign isBrfl    = (aluCtrl_q == OP_BRFL);
    assign isIllegal = (aluCtrl_q == OP_ILLEGAL);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            aluCtrl_q   <= '0;
            aluFunc_q   <= '0;
            aluA_q      <= '0;
            aluB_q      <= '0;
            wbValid_q   <= 1'b0;
            wbResult_q  <= '0;
            wbFlag_q    <= FLAG_NOT_ACTIVED;
            wbBranch_q  <= 1'b0;
            wbIllegal_q <= 1'b0;
            flagReg_q   <= FLAG_NOT_ACTIVED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        aluCtrl_q <= issue_alu_control;
                        aluFunc_q <= issue_func;
                        aluA_q    <= issue_data_a;
                        aluB_q    <= issue_data_b;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (capture) begin
                        wbValid_q   <= 1'b1;
                        wbResult_q  <= isIllegal ? 32'd0 : alu_result;
                        wbFlag_q    <= alu_flag;
                        wbBranch_q  <= isBrfl && alu_branch;
                        wbIllegal_q <= isIllegal;
                        // BRFL reads the flag register and illegal ops must not disturb it.
                        if (!isBrfl && !isIllegal) begin
                            flagReg_q <= alu_flag;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (wb_ready) begin
                        wbValid_q <= 1'b0;
                        if (issue_valid) begin
                            aluCtrl_q <= issue_alu_control;
                            aluFunc_q <= issue_func;
                            aluA_q    <= issue_data_a;
                            aluB_q    <= issue_data_b;
                            state_q   <= ST_EXEC;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign issue_ready = issueReady;
    assign alu_control = aluCtrl_q;
    assign alu_func    = aluFunc_q;
    assign alu_data_a  = aluA_q;
    assign alu_data_b  = aluB_q;
    assign wb_valid    = wbValid_q;
    assign wb_result   = wbResult_q;
    assign wb_flag     = wbFlag_q;
    assign wb_branch   = wbBranch_q;
    assign wb_illegal  = wbIllegal_q;
    assign flag_reg    = flagReg_q;
    assign busy        = (state_q != ST_IDLE);
    assign stall       = issue_valid && !issueReady;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Bench for alu_exec_sequencer: an ALU stub, a transaction-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_alu_exec_sequencer;

    localparam int MULC = 4;
    localparam int DIVC = 8;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_alu_control;
    logic [5:0]  issue_func;
    logic [31:0] issue_data_a;
    logic [31:0] issue_data_b;
    logic [2:0]  alu_control;
    logic [5:0]  alu_func;
    logic [31:0] alu_data_a;
    logic [31:0] alu_data_b;
    logic [31:0] alu_result;
    logic [2:0]  alu_flag;
    logic        alu_branch;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_result;
    logic [2:0]  wb_flag;
    logic        wb_branch;
    logic        wb_illegal;
    logic [2:0]  flag_reg;
    logic        busy;
    logic        stall;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [2:0]  flag;
        logic        branch;
    } aluOut_t;

    // Behavioural ALU: used both as the stub feeding the DUT and by the model.
    function automatic aluOut_t aluRef(input logic [2:0] ctrl, input logic [5:0] func,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] flagIn);
        aluOut_t o;
        o = '0;
        case (ctrl)
            3'b000: begin
                o.result = a + b;
                if (a[31] == b[31] && o.result[31] != a[31]) o.flag = 3'b011;
            end
            3'b001: o.result = a - b;
            3'b010: begin
                if (func == 6'b000010) o.result = a * b;
                else if (func == 6'b000001) begin
                    if (b == 32'd0) begin
                        o.result = 32'hFFFF_FFFF;
                        o.flag   = 3'b010;
                    end else begin
                        o.result = a / b;
                    end
                end else o.result = a + b;
            end
            3'b011: o.result = a & b;
            3'b100: o.result = a | b;
            3'b101: begin
                o.result = a;
                o.flag   = 3'b011;
                o.branch = (b[2:0] != flagIn);
            end
            3'b110: begin
                if (a == b) o.flag = 3'b001;
                else if (a > b) o.flag = 3'b101;
                else o.flag = 3'b100;
            end
            default: begin
                o.result = 32'hDEAD_BEEF;
                o.flag   = 3'b011;
                o.branch = 1'b1;
            end
        endcase
        return o;
    endfunction

    function automatic int modelLat(input logic [2:0] ctrl, input logic [5:0] func,
                                    input logic [31:0] b);
        if (ctrl == 3'b010 && func == 6'b000010) return MULC;
        if (ctrl == 3'b010 && func == 6'b000001) return (b == 32'd0) ? 1 : DIVC;
        return 1;
    endfunction

    aluOut_t stubOut;
    assign stubOut    = aluRef(alu_control, alu_func, alu_data_a, alu_data_b, flag_reg);
    assign alu_result = stubOut.result;
    assign alu_flag   = stubOut.flag;
    assign alu_branch = stubOut.branch;

    alu_exec_sequencer #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_alu_control(issue_alu_control),
        .issue_func       (issue_func),
        .issue_data_a     (issue_data_a),
        .issue_data_b     (issue_data_b),
        .alu_control      (alu_control),
        .alu_func         (alu_func),
        .alu_data_a       (alu_data_a),
        .alu_data_b       (alu_data_b),
        .alu_result       (alu_result),
        .alu_flag         (alu_flag),
        .alu_branch       (alu_branch),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_result        (wb_result),
        .wb_flag          (wb_flag),
        .wb_branch        (wb_branch),
        .wb_illegal       (wb_illegal),
        .flag_reg         (flag_reg),
        .busy             (busy),
        .stall            (stall)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h required %h at %0t", name, actual, expected, $time);
    endtask

    // Reference model state: cycles left in execution and the pending result.
    bit          modelLive = 1'b0;
    int          mLeft     = 0;
    bit          mHave     = 1'b0;
    logic [31:0] mRes;
    logic [2:0]  mWbFlag;
    bit          mWbBr;
    bit          mWbIll;
    logic [2:0]  mFlag;
    logic [2:0]  pCtrl;
    logic [5:0]  pFunc;
    logic [31:0] pA;
    logic [31:0] pB;
    aluOut_t     pOut;

    task automatic modelStep();
        bit readyNow;
        if (!reset) begin
            modelLive = 1'b1;
            mLeft     = 0;
            mHave     = 1'b0;
            mFlag     = 3'b000;
        end else if (modelLive) begin
            readyNow = (mLeft == 0) && (!mHave || wb_ready);
            if (mHave && wb_ready) mHave = 1'b0;
            if (mLeft > 0) begin
                mLeft--;
                if (mLeft == 0) begin
                    mHave   = 1'b1;
                    mWbIll  = (pCtrl == 3'b111);
                    mRes    = mWbIll ? 32'd0 : pOut.result;
                    mWbFlag = pOut.flag;
                    mWbBr   = (pCtrl == 3'b101) ? pOut.branch : 1'b0;
                    if (!mWbIll && pCtrl != 3'b101) mFlag = pOut.flag;
                end
            end
            if (readyNow && issue_valid) begin
                pCtrl = issue_alu_control;
                pFunc = issue_func;
                pA    = issue_data_a;
                pB    = issue_data_b;
                pOut  = aluRef(pCtrl, pFunc, pA, pB, mFlag);
                mLeft = modelLat(pCtrl, pFunc, pB);
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        modelStep();
    end

    initial forever begin
        bit readyExp;
        @(negedge clock);
        if (modelLive) begin
            readyExp = (mLeft == 0) && (!mHave || wb_ready);
            checkOutput("m.issue_ready", {31'd0, issue_ready}, {31'd0, readyExp});
            checkOutput("m.stall", {31'd0, stall}, {31'd0, issue_valid && !readyExp});
            checkOutput("m.busy", {31'd0, busy}, {31'd0, (mLeft != 0) || mHave});
            checkOutput("m.wb_valid", {31'd0, wb_valid}, {31'd0, mHave});
            checkOutput("m.flag_reg", {29'd0, flag_reg}, {29'd0, mFlag});
            if (mHave) begin
                checkOutput("m.wb_result", wb_result, mRes);
                checkOutput("m.wb_flag", {29'd0, wb_flag}, {29'd0, mWbFlag});
                checkOutput("m.wb_branch", {31'd0, wb_branch}, {31'd0, mWbBr});
                checkOutput("m.wb_illegal", {31'd0, wb_illegal}, {31'd0, mWbIll});
            end
            if (mLeft != 0) begin
                checkOutput("m.alu_control", {29'd0, alu_control}, {29'd0, pCtrl});
                checkOutput("m.alu_func", {26'd0, alu_func}, {26'd0, pFunc});
                checkOutput("m.alu_data_a", alu_data_a, pA);
                checkOutput("m.alu_data_b", alu_data_b, pB);
            end
        end
    end

    // Offers one op for exactly one edge; caller guarantees the DUT is ready.
    task automatic applyStimulus(input logic [2:0] ctrl, input logic [5:0] func,
                                 input logic [31:0] a, input logic [31:0] b);
        issue_valid       = 1'b1;
        issue_alu_control = ctrl;
        issue_func        = func;
        issue_data_a      = a;
        issue_data_b      = b;
        @(posedge clock);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic awaitResult(input string name, input int expLat);
        int lat;
        lat = 0;
        while (!wb_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checkOutput({name, " latency"}, lat, expLat);
    endtask

    task automatic consume();
        wb_ready = 1'b1;
        @(posedge clock);
        #1;
        wb_ready = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [2:0] ctrl, input logic [5:0] func,
                         input logic [31:0] a, input logic [31:0] b, input int expLat,
                         input logic [31:0] expRes, input logic [2:0] expFlag,
                         input logic expBr, input logic expIll, input logic [2:0] expFreg);
        applyStimulus(ctrl, func, a, b);
        awaitResult(name, expLat);
        checkOutput({name, " wb_result"}, wb_result, expRes);
        checkOutput({name, " wb_flag"}, {29'd0, wb_flag}, {29'd0, expFlag});
        checkOutput({name, " wb_branch"}, {31'd0, wb_branch}, {31'd0, expBr});
        checkOutput({name, " wb_illegal"}, {31'd0, wb_illegal}, {31'd0, expIll});
        checkOutput({name, " flag_reg"}, {29'd0, flag_reg}, {29'd0, expFreg});
        consume();
    endtask

    initial begin
        reset             = 1'b0;
        issue_valid       = 1'b0;
        issue_alu_control = 3'b000;
        issue_func        = 6'b000000;
        issue_data_a      = 32'd0;
        issue_data_b      = 32'd0;
        wb_ready          = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("reset flag_reg", {29'd0, flag_reg}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset issue_ready", {31'd0, issue_ready}, 32'd1);
        checkOutput("reset alu_data_a", alu_data_a, 32'd0);
        checkOutput("reset wb_result", wb_result, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        runOp("addi", 3'b000, 6'd0, 32'd5, 32'd7, 1, 32'd12, 3'b000, 1'b0, 1'b0, 3'b000);
        checkOutput("addi idle busy", {31'd0, busy}, 32'd0);

        // MUL with a second op waiting, then a back-to-back accept of that op.
        applyStimulus(3'b010, 6'b000010, 32'd3, 32'd4);
        issue_valid       = 1'b1;
        issue_alu_control = 3'b011;
        issue_func        = 6'd0;
        issue_data_a      = 32'h0000_00F0;
        issue_data_b      = 32'h0000_003C;
        checkOutput("mul stall", {31'd0, stall}, 32'd1);
        checkOutput("mul busy", {31'd0, busy}, 32'd1);
        checkOutput("mul alu_data_a", alu_data_a, 32'd3);
        awaitResult("mul", 4);
        checkOutput("mul wb_result", wb_result, 32'd12);
        wb_ready = 1'b1;
        @(posedge clock);
        #1;
        wb_ready    = 1'b0;
        issue_valid = 1'b0;
        checkOutput("b2b wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("b2b busy", {31'd0, busy}, 32'd1);
        checkOutput("b2b alu_control", {29'd0, alu_control}, 32'd3);
        awaitResult("andi", 1);
        checkOutput("andi wb_result", wb_result, 32'h0000_0030);
        consume();

        runOp("div0", 3'b010, 6'b000001, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 3'b010, 1'b0, 1'b0, 3'b010);
        runOp("div", 3'b010, 6'b000001, 32'd9, 32'd3, 8, 32'd3, 3'b000, 1'b0, 1'b0, 3'b000);
        runOp("cmp", 3'b110, 6'd0, 32'd6, 32'd6, 1, 32'd0, 3'b001, 1'b0, 1'b0, 3'b001);
        runOp("brfl001", 3'b101, 6'd0, 32'h100, 32'd1, 1, 32'h100, 3'b011, 1'b0, 1'b0, 3'b001);
        runOp("brfl101", 3'b101, 6'd0, 32'h200, 32'd5, 1, 32'h200, 3'b011, 1'b1, 1'b0, 3'b001);
        runOp("illegal", 3'b111, 6'd0, 32'd1, 32'd2, 1, 32'd0, 3'b011, 1'b0, 1'b1, 3'b001);

        // Result held under back-pressure while a new op waits.
        applyStimulus(3'b100, 6'd0, 32'h0F, 32'hF0);
        awaitResult("ori", 1);
        issue_valid       = 1'b1;
        issue_alu_control = 3'b001;
        issue_func        = 6'd0;
        issue_data_a      = 32'd10;
        issue_data_b      = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checkOutput("hold wb_result", wb_result, 32'h0000_00FF);
            checkOutput("hold issue_ready", {31'd0, issue_ready}, 32'd0);
        end
        wb_ready = 1'b1;
        @(posedge clock);
        #1;
        wb_ready    = 1'b0;
        issue_valid = 1'b0;
        checkOutput("hold b2b busy", {31'd0, busy}, 32'd1);
        checkOutput("hold b2b alu_control", {29'd0, alu_control}, 32'd1);
        awaitResult("subi", 1);
        checkOutput("subi wb_result", wb_result, 32'd7);
        consume();

        // Reset in the middle of a MUL discards it and clears the flag register.
        runOp("cmp73", 3'b110, 6'd0, 32'd7, 32'd3, 1, 32'd0, 3'b101, 1'b0, 1'b0, 3'b101);
        applyStimulus(3'b010, 6'b000010, 32'd2, 32'd2);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        checkOutput("midrst wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("midrst busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst flag_reg", {29'd0, flag_reg}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            checkOutput("midrst no result", {31'd0, wb_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
